muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage of the multicycle core.
- Accepts one M-extension operation per start pulse and computes it over 32+ clock cycles.
- Holds exBusy high while working, which freezes the phase clock generator in the EX phase.
- Returns a registered 32-bit result with a one-cycle done pulse.

Parameters:
- XLEN, 32, operand/result width (only 32 is supported).
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- CLK  input  1  core clock
- RST  input  1  synchronous active-high reset
- start  input  1  one-cycle request, sampled on rising CLK
- funct3  input  3  M-op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  input  32  operand A (dividend / multiplicand)
- rs2  input  32  operand B (divisor / multiplier)
- exBusy  output  1  operation in flight; stalls phase advance
- done  output  1  one-cycle pulse; result valid
- result  output  32  registered result, held until next done

Behaviour:
- One clock domain, CLK. Reset is synchronous and active-high on RST.
- Reset (any time, including mid-operation):
  - state=IDLE, counter=0, all datapath registers 0.
  - exBusy=0, done=0, result=0.
  - Any operation in flight is abandoned with no done pulse.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 latches funct3 and the operand magnitudes, plus sign flags per op:
    - MULH, DIV, REM: both operands signed.
    - MULHSU: rs1 signed only.
    - MUL and the unsigned ops: no signed operands.
  - Normal case: next state CALC, counter=0.
  - Special cases go straight to DONE, result registered in the same edge:
    - Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> rs1.
    - Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): DIV -> 0x80000000, REM -> 0.
- CALC, 32 cycles, counter 0..31:
  - Multiply: shift-add on the unsigned magnitudes into a 64-bit accumulator.
  - Divide: restoring divide producing a 32-bit quotient and 32-bit remainder.
  - At counter=31, next state FIX.
- FIX, 1 cycle, registers result:
  - Negate the 64-bit product if operand signs differ.
  - MUL takes bits [31:0]; MULH/MULHSU/MULHU take bits [63:32].
  - Quotient is negated if signs differ (signed DIV only).
  - Remainder takes the sign of the dividend (signed REM only).
  - Next state DONE.
- DONE, 1 cycle: done=1, next state IDLE.
- exBusy = (start & state==IDLE) | state==CALC | state==FIX.
  - The combinational start term prevents a gap, so the phase generator never sees exBusy low on the start cycle.
- Latency, with start sampled in cycle T:
  - Normal op: CALC spans T+1..T+32, FIX at T+33, done=1 in T+34; exBusy high T..T+33, low in T+34.
  - Special case: done=1 in T+1; exBusy high in T only.
- start while state≠IDLE: ignored with no side effect; operands are not re-latched.
- start in the DONE cycle: ignored; a new op may be accepted from the following IDLE cycle.
- rs1/rs2/funct3 may change after the start cycle without affecting the result.
- result: changes only on the edge entering DONE; stable otherwise.
- Arithmetic:
  - Magnitude of 0x80000000 is 0x80000000, treated as unsigned 33-bit-safe.
  - Negation is two's complement, truncated to the destination width.

Decomposition:
- Package shrv32_m_pkg:
  - funct3 enum m_op_e (MUL..REMU).
  - State enum md_state_e (IDLE, CALC, FIX, DONE).
  - Constants XLEN=32, DIV0_QUOT=32'hFFFFFFFF, INT_MIN=32'h80000000.
- No sub-module: the datapath is one shared shift register pair, so a single module is natural.

Test Plan:
- MUL rs1=7, rs2=-3 (0xFFFFFFFD): start at T -> exBusy high T..T+33; done at T+34; result=0xFFFFFFEB.
- MULH 0x80000000 x 0x80000000 -> result=0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFE. MULHSU rs1=-1, rs2=2 -> result=0xFFFFFFFF.
- Signed divide, rs1=-7, rs2=2: DIV -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases: DIV x/0 (x=5) -> done at T+1, result=0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM same operands -> 0.
- start pulsed again at T+10 with different operands -> ignored; done at T+34 carries the first result; result stays stable afterwards.
- RST asserted at T+15 mid-CALC -> next cycle exBusy=0, done=0, result=0; a new start after reset completes normally.

Source files
------------

// File: rtl/shrv32_m_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package shrv32_m_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } m_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_e;

  // Magnitude of INT_MIN wraps back to 0x80000000, which is correct as unsigned.
  function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide
// share one 64-bit shift register; signs are applied in a single FIX cycle.
module muldiv_unit
  import shrv32_m_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  output logic             exBusy,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic [1:0]       dbg_state
);

  md_state_e state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  m_op_e             op_q;
  logic              neg_a, neg_b;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;

  m_op_e           in_op;
  logic            sgn_a, sgn_b, div0, ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;

  always_comb begin
    in_op    = m_op_e'(funct3);
    sgn_a    = (in_op == MULH) || (in_op == MULHSU) || (in_op == DIV) || (in_op == REM);
    sgn_b    = (in_op == MULH) || (in_op == DIV) || (in_op == REM);
    a_mag    = mag(rs1, sgn_a);
    b_mag    = mag(rs2, sgn_b);
    div0     = funct3[2] && (rs2 == '0);
    ovf      = ((in_op == DIV) || (in_op == REM)) && (rs1 == INT_MIN) && (rs2 == '1);
    special  = div0 || ovf;
    // funct3[1] selects the remainder flavour among the divide ops.
    spec_res = div0 ? (funct3[1] ? rs1 : DIV0_QUOT) : (funct3[1] ? '0 : INT_MIN);
  end

  // One iteration step; multiply shifts the product right, divide shifts left.
  logic [XLEN:0]     mul_sum;
  logic [XLEN+1:0]   div_trial;
  logic [2*XLEN-1:0] acc_step;

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    div_trial = {1'b0, acc[2*XLEN-1:XLEN-1]} - {2'b00, opnd};
    if (op_q[2]) begin
      if (div_trial[XLEN+1])
        acc_step = {acc[2*XLEN-2:0], 1'b0};
      else
        acc_step = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot, rem, fix_res;

  always_comb begin
    prod_s = (neg_a ^ neg_b) ? (~acc + 1'b1) : acc;
    quot   = acc[XLEN-1:0];
    rem    = acc[2*XLEN-1:XLEN];
    if (op_q[2])
      fix_res = op_q[1] ? (neg_a ? (~rem + 1'b1) : rem)
                        : ((neg_a ^ neg_b) ? (~quot + 1'b1) : quot);
    else
      fix_res = (op_q == MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = special ? DONE : CALC;
      CALC:    if (cnt == '1) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    exBusy    = (start && (state == IDLE)) || (state == CALC) || (state == FIX);
    done      = (state == DONE);
    dbg_state = state;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt    <= '0;
      op_q   <= MUL;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_q  <= in_op;
          neg_a <= sgn_a && rs1[XLEN-1];
          neg_b <= sgn_b && rs2[XLEN-1];
          cnt   <= '0;
          // Divide shifts the dividend out of acc and compares against the
          // divisor; multiply shifts the multiplier out and adds the multiplicand.
          acc   <= funct3[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
          opnd  <= funct3[2] ? b_mag : a_mag;
          if (special) result <= spec_res;
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          acc <= acc_step;
        end
        FIX:     result <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a timing/value model per accepted op,
// checked against the DUT every cycle.
module tb_muldiv_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        exBusy, done;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  muldiv_unit dut (
    .CLK(CLK), .RST(RST), .start(start), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .exBusy(exBusy), .done(done),
    .result(result), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- model state ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  int          t_start = -10;
  int          t_done  = -10;
  logic [31:0] last_res = '0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    case (op)
      3'b000: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Call in the cycle start is driven; the op is taken only if the unit is idle.
  task automatic try_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; funct3 = op; rs1 = a; rs2 = b;
    if (cyc > t_done) begin
      t_start = cyc;
      t_done  = cyc + (is_special(op, a, b) ? 1 : 34);
      exp_q.push_back(model(op, a, b));
    end
  endtask

  task automatic model_reset();
    t_start  = -10;
    t_done   = -10;
    last_res = '0;
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lit, input int restart_at, input int rst_at);
    int  span;
    bit  rst_pending;
    rst_pending = 0;
    check("model_pin", model(op, a, b), lit);
    @(posedge CLK); #1;
    try_start(op, a, b);
    span = t_done - cyc + 2;
    for (int k = 1; k <= span; k++) begin
      @(posedge CLK);
      if (rst_pending) begin
        model_reset();
        rst_pending = 0;
      end
      #1;
      RST    = 1'b0;
      start  = 1'b0;
      funct3 = 3'($urandom_range(0, 7));
      rs1    = $urandom;
      rs2    = $urandom;
      if (k == restart_at) try_start(3'b000, 32'd3, 32'd3);
      if (k == rst_at) begin
        RST = 1'b1;
        rst_pending = 1;
      end
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge CLK) begin
    if (cyc >= 1) begin
      logic exp_busy, exp_done;
      logic [31:0] e;
      exp_busy = (cyc >= t_start) && (cyc < t_done);
      exp_done = (cyc == t_done);
      check("exBusy", {31'b0, exBusy}, {31'b0, exp_busy});
      check("done", {31'b0, done}, {31'b0, exp_done});
      if (exp_done) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL result_queue_empty cyc=%0d got=%h want=<queued value>", cyc, result);
        end else begin
          e = exp_q.pop_front();
          check("result_done", result, e);
          last_res = e;
        end
      end else begin
        check("result_hold", result, last_res);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    RST = 1'b1; start = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(posedge CLK);

    run_op(3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, -1, -1); // MUL
    run_op(3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, -1, -1); // MULH
    run_op(3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, -1, -1); // MULHU
    run_op(3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, -1, -1); // MULHSU
    run_op(3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, -1, -1); // MULH -1*-1
    run_op(3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, -1, -1); // DIV -7/2
    run_op(3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, -1, -1); // REM -7%2
    run_op(3'b101, 32'd100,        32'd7,         32'd14,        10, -1); // DIVU + ignored restart
    run_op(3'b111, 32'd100,        32'd7,         32'd2,         -1, -1); // REMU
    run_op(3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, -1, -1); // DIV by zero
    run_op(3'b111, 32'd5,          32'd0,         32'd5,         -1, -1); // REMU by zero
    run_op(3'b110, 32'd7,          32'd0,         32'd7,         -1, -1); // REM by zero
    run_op(3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, -1, -1); // DIV overflow
    run_op(3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, -1, -1); // REM overflow
    run_op(3'b000, 32'd1000,       32'd1000,      32'd1000000,   -1, 15); // reset mid-CALC
    run_op(3'b100, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, -1, -1); // DIV -100/7
    run_op(3'b110, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFFE, -1, -1); // REM -100%7

    repeat (3) @(posedge CLK);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
